conversor_bcd: RTL and testbench

Sequential binary-to-BCD converter (shift-and-add-3) downstream of the 4x4 shift-add multiplier. Captures the 8-bit `Produto` when the multiplier pulses `Done`, converts it to hundreds/tens/units, and drives three active-low 7-segment displays. Uses the same `St`/`Idle`/`Done` handshake as the multiplier, so the multiplier's `Done` connects directly to this block's `St`.

---
 rtl/conversor_bcd.sv | 140 ++++++++++++++
 tb/tb_conversor_bcd.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/conversor_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with 7-segment outputs.
// Accepts a value on St while idle, runs WIDTH shift iterations, then pulses
// Done for one cycle with the registered hundreds/tens/units digits.
module conversor_bcd #(
  parameter int unsigned WIDTH = 8,
  parameter bit          BLANK = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             St,
  input  logic [WIDTH-1:0] Binario,
  output logic             Idle,
  output logic             Done,
  output logic [3:0]       Centenas,
  output logic [3:0]       Dezenas,
  output logic [3:0]       Unidades,
  output logic [6:0]       Hex2,
  output logic [6:0]       Hex1,
  output logic [6:0]       Hex0
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FIM  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [11:0]      scratch_q, scratch_d;
  logic [11:0]      adjusted;
  logic [11:0]      shifted;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       cen_d, dez_d, uni_d;

  // Add 3 to a BCD digit that would overflow past 9 after the next doubling.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Active-low {g,f,e,d,c,b,a}; 10-15 cannot occur and are shown as dark.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // One shift-and-add-3 iteration: correct each digit, then shift in the next binary bit.
  always_comb begin
    adjusted = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};
    shifted  = {adjusted[10:0], shift_q[WIDTH-1]};
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state, datapath next values and handshake outputs.
  always_comb begin
    state_next = state;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    cen_d      = Centenas;
    dez_d      = Dezenas;
    uni_d      = Unidades;
    Idle       = 1'b0;
    Done       = 1'b0;
    case (state)
      IDLE: begin
        Idle = 1'b1;
        if (St) begin
          shift_d    = Binario;
          scratch_d  = '0;
          cnt_d      = 4'(WIDTH);
          state_next = CONV;
        end
      end
      CONV: begin
        scratch_d = shifted;
        shift_d   = shift_q << 1;
        cnt_d     = cnt_q - 4'd1;
        // Digits load from the final iteration's result directly, so the
        // displays jump from the old value to the new one with no partials.
        if (cnt_q == 4'd1) begin
          cen_d      = shifted[11:8];
          dez_d      = shifted[7:4];
          uni_d      = shifted[3:0];
          state_next = FIM;
        end
      end
      FIM: begin
        Done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and digit registers.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      Centenas  <= '0;
      Dezenas   <= '0;
      Unidades  <= '0;
    end else begin
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      Centenas  <= cen_d;
      Dezenas   <= dez_d;
      Unidades  <= uni_d;
    end
  end

  // Segment decode with optional leading-zero blanking; units always lit.
  always_comb begin
    Hex0 = seg7(Unidades);
    Hex1 = (BLANK && (Centenas == 4'd0) && (Dezenas == 4'd0)) ? '1 : seg7(Dezenas);
    Hex2 = (BLANK && (Centenas == 4'd0)) ? '1 : seg7(Centenas);
  end

endmodule

// File: tb/tb_conversor_bcd.sv
// Directed testbench for conversor_bcd (WIDTH=8, BLANK=1).
module tb_conversor_bcd;

  logic       clk = 1'b0;
  logic       reset;
  logic       st;
  logic [7:0] binario;
  logic       Idle, Done;
  logic [3:0] Centenas, Dezenas, Unidades;
  logic [6:0] Hex2, Hex1, Hex0;

  int checks = 0;
  int errors = 0;
  logic [3:0] prev_c = 4'd0, prev_d = 4'd0, prev_u = 4'd0;

  localparam logic [6:0] BLK = 7'b1111111;

  conversor_bcd #(.WIDTH(8), .BLANK(1'b1)) dut (
    .Clk(clk), .Reset(reset), .St(st), .Binario(binario),
    .Idle(Idle), .Done(Done),
    .Centenas(Centenas), .Dezenas(Dezenas), .Unidades(Unidades),
    .Hex2(Hex2), .Hex1(Hex1), .Hex0(Hex0)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start a conversion on the next edge and follow it to completion.
  // poke>0 pulses St (Binario=200) for one cycle that many edges into CONV.
  task automatic run_conv(input logic [7:0] v, input logic [3:0] ec, ed, eu,
                          input logic [6:0] h2, h1, h0, input bit chk_hex, input int poke);
    int n;
    @(negedge clk); st = 1'b1; binario = v;
    @(negedge clk); st = 1'b0; binario = 8'd0;
    check("idle_fall", 32'(Idle), 32'd0);
    n = 0;
    while (n < 20) begin
      if (poke != 0 && n == poke) begin st = 1'b1; binario = 8'd200; end
      @(negedge clk); n++; st = 1'b0;
      if (Done) break;
      check("hold", 32'({Centenas, Dezenas, Unidades}), 32'({prev_c, prev_d, prev_u}));
    end
    check("latency", 32'(n), 32'd8);
    check("centenas", 32'(Centenas), 32'(ec));
    check("dezenas", 32'(Dezenas), 32'(ed));
    check("unidades", 32'(Unidades), 32'(eu));
    if (chk_hex) begin
      check("hex2", 32'(Hex2), 32'(h2));
      check("hex1", 32'(Hex1), 32'(h1));
      check("hex0", 32'(Hex0), 32'(h0));
    end
    @(negedge clk);
    check("done_fall", 32'(Done), 32'd0);
    check("idle_rise", 32'(Idle), 32'd1);
    prev_c = ec; prev_d = ed; prev_u = eu;
  endtask

  initial begin
    int n;
    int p;
    bit seen;

    // Reset for two edges.
    reset = 1'b0; st = 1'b0; binario = 8'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("rst_idle", 32'(Idle), 32'd1);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_digits", 32'({Centenas, Dezenas, Unidades}), 32'd0);
    check("rst_hex0", 32'(Hex0), 32'(7'b1000000));
    check("rst_hex1", 32'(Hex1), 32'(BLK));
    check("rst_hex2", 32'(Hex2), 32'(BLK));

    // Directed values.
    run_conv(8'd91,  4'd0, 4'd9, 4'd1, BLK,         7'b0010000, 7'b1111001, 1'b1, 0);
    run_conv(8'd225, 4'd2, 4'd2, 4'd5, 7'b0100100, 7'b0100100, 7'b0010010, 1'b1, 0);
    run_conv(8'd255, 4'd2, 4'd5, 4'd5, 7'b0100100, 7'b0010010, 7'b0010010, 1'b1, 0);
    run_conv(8'd0,   4'd0, 4'd0, 4'd0, BLK,         BLK,         7'b1000000, 1'b1, 0);
    run_conv(8'd100, 4'd1, 4'd0, 4'd0, 7'b1111001, 7'b1000000, 7'b1000000, 1'b1, 0);

    // Busy protection: St pulsed with 200 mid-conversion must be ignored.
    run_conv(8'd47,  4'd0, 4'd4, 4'd7, BLK,         7'b0011001, 7'b1111000, 1'b1, 3);
    seen = 1'b0;
    repeat (12) begin @(negedge clk); seen |= Done; end
    check("busy_no_second_done", 32'(seen), 32'd0);
    check("busy_digits", 32'({Centenas, Dezenas, Unidades}), 32'h047);

    // Reset mid-conversion aborts without Done.
    @(negedge clk); st = 1'b1; binario = 8'd199;
    @(negedge clk); st = 1'b0; binario = 8'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_idle", 32'(Idle), 32'd1);
    check("abort_done", 32'(Done), 32'd0);
    check("abort_digits", 32'({Centenas, Dezenas, Unidades}), 32'd0);
    check("abort_hex0", 32'(Hex0), 32'(7'b1000000));
    check("abort_hex2", 32'(Hex2), 32'(BLK));
    seen = 1'b0;
    repeat (12) begin @(negedge clk); seen |= Done; end
    check("abort_no_done", 32'(seen), 32'd0);
    prev_c = 4'd0; prev_d = 4'd0; prev_u = 4'd0;
    run_conv(8'd199, 4'd1, 4'd9, 4'd9, 7'b1111001, 7'b0010000, 7'b0010000, 1'b1, 0);

    // Reset together with St: reset wins, no conversion starts.
    @(negedge clk); reset = 1'b0; st = 1'b1; binario = 8'd5;
    @(negedge clk); reset = 1'b1; st = 1'b0;
    check("rst_st_idle", 32'(Idle), 32'd1);
    check("rst_st_digits", 32'({Centenas, Dezenas, Unidades}), 32'd0);
    @(negedge clk);
    check("rst_st_still_idle", 32'(Idle), 32'd1);

    // St held high: one conversion every WIDTH+2 cycles.
    @(negedge clk); st = 1'b1; binario = 8'd37;
    n = 0;
    do begin @(negedge clk); n++; end while (!Done && n < 30);
    check("thru_first_done", 32'(Done), 32'd1);
    n = 0;
    do begin @(negedge clk); n++; end while (!Done && n < 30);
    check("thru_period", 32'(n), 32'd10);
    check("thru_digits", 32'({Centenas, Dezenas, Unidades}), 32'h037);
    st = 1'b0;
    @(negedge clk);
    check("thru_idle", 32'(Idle), 32'd1);
    prev_c = 4'd0; prev_d = 4'd3; prev_u = 4'd7;

    // Integration sweep: products of all 4x4 operand pairs.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        p = a * b;
        run_conv(8'(p), 4'(p / 100), 4'((p / 10) % 10), 4'(p % 10), BLK, BLK, BLK, 1'b0, 0);
        check("sweep_value", 32'(Centenas) * 100 + 32'(Dezenas) * 10 + 32'(Unidades), 32'(p));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
